bldc_cmd_sequencer: RTL
=======================

BLDC_CMD_SEQUENCER -- requirements
Module: bldc_cmd_sequencer

Interface
REQ-001 The module SHALL have parameter DEADTIME, default 16, giving the number of cycles a reversing motor is held off before the new direction is applied (range 1..255).
REQ-002 The module SHALL have parameter STALL_TIMEOUT, default 1024, giving the number of consecutive driven cycles without a hall edge before a stall is declared (range 2..65535).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received UART command byte.
REQ-006 rx_valid  input  1  one-cycle strobe qualifying rx_data.
REQ-007 HS1, HS2, HS3, HS4  input  3 each  hall sensor codes of motors 1..4, asynchronous to clk.
REQ-008 cmd_out  output  8  registered command to the commutation block; field [2i+1:2i] drives motor i+1.
REQ-009 busy  output  1  high while a deadtime sequence is in progress.
REQ-010 stall  output  4  per-motor sticky stall flags.
REQ-011 hall_fault  output  4  per-motor illegal-hall-code flags.

Function
REQ-012 Each 2-bit mode field SHALL be encoded as 00 off, 01 forward, 10 reverse, 11 brake; this applies to both rx_data and cmd_out.
REQ-013 Each HSx SHALL pass through a 2-flop synchronizer; all hall logic SHALL use the synchronized value.
REQ-014 A hall edge for motor i SHALL be a difference between the synchronized code and its value one cycle earlier.
REQ-015 The applied command register cur_cmd SHALL hold the last command fully applied.
REQ-016 A field SHALL be "reversing" when its cur_cmd mode is 01 and its new mode is 10, or its cur_cmd mode is 10 and its new mode is 01.
REQ-017 The FSM SHALL have three states: IDLE, DEAD and APPLY.
REQ-018 In IDLE, when a command is taken and no field is reversing, cur_cmd SHALL load the command and the FSM SHALL stay in IDLE; cmd_out reflects it on the next edge (latency 1).
REQ-019 In IDLE, when a command is taken and any field is reversing, the FSM SHALL load the deadtime counter with DEADTIME and enter DEAD.
REQ-020 While in DEAD, cmd_out SHALL present reversing fields as 00 and all other fields at their new modes.
REQ-021 When the deadtime counter reaches 0 in DEAD, the FSM SHALL enter APPLY for one cycle, load cur_cmd with the full command, then return to IDLE.
REQ-022 The intermediate cmd_out SHALL appear 1 cycle after the command is taken; the final cmd_out SHALL appear DEADTIME+1 cycles after it.
REQ-023 A single-entry pending buffer SHALL capture rx_valid bytes arriving in DEAD or APPLY, with the latest byte overwriting any older one.
REQ-024 In IDLE, the pending byte SHALL be taken before a simultaneous rx_valid byte, and the rx_valid byte SHALL then become the new pending byte.
REQ-025 Reversal of a pending byte SHALL be evaluated against cur_cmd at the time it is taken.
REQ-026 busy SHALL equal (state != IDLE) or pending valid.
REQ-027 Motor i SHALL be "driven" when its cur_cmd mode is 01 or 10.
REQ-028 The stall counter for motor i SHALL clear on a hall edge, when motor i is not driven, or when its mode changes.
REQ-029 Otherwise the stall counter SHALL increment and saturate at STALL_TIMEOUT.
REQ-030 stall[i] SHALL set on the cycle after the stall counter reaches STALL_TIMEOUT.
REQ-031 stall[i] SHALL clear only when cur_cmd loads mode 00 or 11 into field i, or on reset.
REQ-032 hall_fault[i] SHALL be registered and equal 1 when motor i is driven and its synchronized code is 000 or 111; it clears when the condition ends.
REQ-033 Masking: cmd_out field i SHALL be forced to 00 while stall[i] or hall_fault[i] is set; cur_cmd itself is not altered by the mask.
REQ-034 When rx_valid arrives in the same cycle that stall sets, the stall SHALL take effect and the command SHALL still be accepted per REQ-018 to REQ-024.

Reset
REQ-035 On rst, the module SHALL clear cmd_out, cur_cmd, busy, stall, hall_fault, the pending buffer, all counters and the synchronizers, and SHALL enter IDLE.
REQ-036 rst during DEAD SHALL abort the sequence, with cmd_out = 00000000 on the next cycle and no later application of the command.

Verification
REQ-037 After reset, rx_data=01010101 with a pulse and halls toggling -> cmd_out=01010101 one cycle later, busy stays 0.
REQ-038 With cur_cmd=00000001, DEADTIME=4, rx_data=00000010 -> cmd_out=00000000 for 4 cycles, busy=1, then 00000010, busy=0.
REQ-039 During that DEAD window, bytes 01000000 then 10000000 are sent -> only 10000000 is applied, 1 cycle after returning to IDLE.
REQ-040 With cur_cmd=01000000, STALL_TIMEOUT=64 and HS4 frozen -> stall=1000 and cmd_out=00000000 after 64 driven cycles (plus sync); rx 00000000 clears stall; a hall edge at cycle 63 prevents the stall.
REQ-041 Driving motor 2 with HS2=111 -> hall_fault=0010 and field [3:2]=00 on cmd_out; HS2 set back to 011 -> field restored within 3 cycles.
REQ-042 Asserting rst in the middle of DEAD -> all outputs 0 the next cycle, and the pending and in-flight commands are never applied.

Source files
------------

// File: rtl/bldc_cmd_sequencer.sv
// rtl/bldc_cmd_sequencer.sv - four-motor BLDC command sequencer
// Applies UART mode bytes with reversal deadtime, hall stall and fault masking.
module bldc_cmd_sequencer #(
  parameter int DEADTIME      = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [2:0] HS1,
  input  logic [2:0] HS2,
  input  logic [2:0] HS3,
  input  logic [2:0] HS4,
  output logic [7:0] cmd_out,
  output logic       busy,
  output logic [3:0] stall,
  output logic [3:0] hall_fault
);

  localparam logic [7:0]  DT = 8'(DEADTIME);
  localparam logic [15:0] ST = 16'(STALL_TIMEOUT);

  typedef enum logic [1:0] {IDLE, DEAD, APPLY} state_t;

  state_t     state, state_nxt;
  logic [7:0] cur_cmd, cur_cmd_nxt;
  logic [7:0] new_cmd, new_cmd_nxt;
  logic [7:0] inter_cmd, inter_cmd_nxt;
  logic [7:0] pend_data, pend_data_nxt;
  logic       pend_valid, pend_valid_nxt;
  logic [7:0] dead_cnt, dead_cnt_nxt;
  logic       cur_load;
  logic [7:0] take_cmd, rev_zero;
  logic       any_rev;
  logic [7:0] disp, cmd_out_nxt;

  logic [3:0][2:0]  hs_in, hs_s1, hs_s2, hs_prev;
  logic [3:0][15:0] stall_cnt, stall_cnt_nxt;
  logic [3:0]       stall_nxt, hf_nxt, driven, hall_edge, mode_chg, out_mask;

  assign hs_in = {HS4, HS3, HS2, HS1};
  assign busy  = (state != IDLE) || pend_valid;

  // A pending byte always has priority over a byte arriving in the same cycle.
  always_comb begin
    take_cmd = pend_valid ? pend_data : rx_data;
    rev_zero = take_cmd;
    any_rev  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((cur_cmd[2*i +: 2] == 2'b01 && take_cmd[2*i +: 2] == 2'b10) ||
          (cur_cmd[2*i +: 2] == 2'b10 && take_cmd[2*i +: 2] == 2'b01)) begin
        rev_zero[2*i +: 2] = 2'b00;
        any_rev            = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_cmd_nxt    = cur_cmd;
    new_cmd_nxt    = new_cmd;
    inter_cmd_nxt  = inter_cmd;
    pend_valid_nxt = pend_valid;
    pend_data_nxt  = pend_data;
    dead_cnt_nxt   = dead_cnt;
    cur_load       = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid || rx_valid) begin
          if (pend_valid) begin
            pend_valid_nxt = rx_valid;
            pend_data_nxt  = rx_data;
          end
          if (any_rev) begin
            new_cmd_nxt   = take_cmd;
            inter_cmd_nxt = rev_zero;
            dead_cnt_nxt  = DT;
            state_nxt     = DEAD;
          end else begin
            cur_cmd_nxt = take_cmd;
            cur_load    = 1'b1;
          end
        end
      end
      DEAD: begin
        dead_cnt_nxt = dead_cnt - 8'd1;
        if (dead_cnt == 8'd1) begin
          state_nxt   = APPLY;
          cur_cmd_nxt = new_cmd;
          cur_load    = 1'b1;
        end
      end
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && rx_valid) begin
      pend_valid_nxt = 1'b1;
      pend_data_nxt  = rx_data;
    end
  end

  // The mask also covers the cycle a stall clears, so a stalled motor is never
  // briefly re-driven with its old mode before the new cur_cmd reaches cmd_out.
  always_comb begin
    disp          = (state == DEAD) ? inter_cmd : cur_cmd;
    cmd_out_nxt   = disp;
    stall_cnt_nxt = stall_cnt;
    stall_nxt     = stall;
    hf_nxt        = '0;
    driven        = '0;
    hall_edge     = '0;
    mode_chg      = '0;
    out_mask      = '0;
    for (int i = 0; i < 4; i++) begin
      driven[i]    = (cur_cmd[2*i +: 2] == 2'b01) || (cur_cmd[2*i +: 2] == 2'b10);
      hall_edge[i] = hs_s2[i] != hs_prev[i];
      mode_chg[i]  = cur_cmd_nxt[2*i +: 2] != cur_cmd[2*i +: 2];
      if (hall_edge[i] || !driven[i] || mode_chg[i])
        stall_cnt_nxt[i] = '0;
      else if (stall_cnt[i] != ST)
        stall_cnt_nxt[i] = stall_cnt[i] + 16'd1;
      if (cur_load && (cur_cmd_nxt[2*i +: 2] == 2'b00 || cur_cmd_nxt[2*i +: 2] == 2'b11))
        stall_nxt[i] = 1'b0;
      else
        stall_nxt[i] = stall[i] || (stall_cnt[i] == ST);
      hf_nxt[i]   = driven[i] && (hs_s2[i] == 3'b000 || hs_s2[i] == 3'b111);
      out_mask[i] = stall[i] || stall_nxt[i] || hf_nxt[i];
      if (out_mask[i])
        cmd_out_nxt[2*i +: 2] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_cmd    <= '0;
      new_cmd    <= '0;
      inter_cmd  <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      dead_cnt   <= '0;
      cmd_out    <= '0;
      stall      <= '0;
      hall_fault <= '0;
      stall_cnt  <= '0;
      hs_s1      <= '0;
      hs_s2      <= '0;
      hs_prev    <= '0;
    end else begin
      state      <= state_nxt;
      cur_cmd    <= cur_cmd_nxt;
      new_cmd    <= new_cmd_nxt;
      inter_cmd  <= inter_cmd_nxt;
      pend_valid <= pend_valid_nxt;
      pend_data  <= pend_data_nxt;
      dead_cnt   <= dead_cnt_nxt;
      cmd_out    <= cmd_out_nxt;
      stall      <= stall_nxt;
      hall_fault <= hf_nxt;
      stall_cnt  <= stall_cnt_nxt;
      hs_s1      <= hs_in;
      hs_s2      <= hs_s1;
      hs_prev    <= hs_s2;
    end
  end

endmodule
